// File: rtl/game_flow_controller.sv
`default_nettype none
// ============================================================================
//  Module      : game_flow_controller
//  Description : Round sequencer for the game logic. Walks the flow
//                IDLE -> READY -> PLAY -> DYING -> (READY | GAME_OVER),
//                tracks remaining lives, emits the one-cycle move-enable
//                pulse and the sprite-reset / freeze / game-over levels.
//  Revision    : 1.0  initial release
// ============================================================================
module game_flow_controller #(
    parameter int NUM_LIVES    = 3,
    parameter int LIVES_W      = 3,
    parameter int READY_FRAMES = 120,
    parameter int DEATH_FRAMES = 60,
    parameter int MOVE_DIV     = 2,
    parameter int CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_btn,
    input  logic               frame_tick,
    input  logic               pacman_is_dead,
    output logic               move_en,
    output logic               sprites_reset,
    output logic               freeze,
    output logic [LIVES_W-1:0] lives_left,
    output logic               game_over,
    output logic [2:0]         game_state
);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_READY     = 3'd1;
    localparam logic [2:0] c_ST_PLAY      = 3'd2;
    localparam logic [2:0] c_ST_DYING     = 3'd3;
    localparam logic [2:0] c_ST_GAME_OVER = 3'd4;

    localparam logic [CNT_W-1:0]   c_READY_LAST = CNT_W'(READY_FRAMES - 1);
    localparam logic [CNT_W-1:0]   c_DEATH_LAST = CNT_W'(DEATH_FRAMES - 1);
    localparam logic [CNT_W-1:0]   c_MOVE_LAST  = CNT_W'(MOVE_DIV - 1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE    = CNT_W'(1);
    localparam logic [LIVES_W-1:0] c_LIVES_INIT = LIVES_W'(NUM_LIVES);
    localparam logic [LIVES_W-1:0] c_LIVES_ONE  = LIVES_W'(1);

    logic [2:0]         r_state;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [CNT_W-1:0]   r_move_cnt;
    logic [LIVES_W-1:0] r_lives;
    logic               r_start_prev;
    logic               r_move_en;
    logic               r_sprites_reset;
    logic               r_freeze;
    logic               r_game_over;

    logic [2:0]         w_state_nxt;
    logic [CNT_W-1:0]   w_frame_cnt_nxt;
    logic [CNT_W-1:0]   w_move_cnt_nxt;
    logic [LIVES_W-1:0] w_lives_nxt;
    logic               w_move_en_nxt;
    logic               w_sprites_reset_nxt;
    logic               w_freeze_nxt;
    logic               w_game_over_nxt;
    logic               w_start_pe;

    // Rising edge of the (already synchronised) start button
    assign w_start_pe = start_btn & ~r_start_prev;

    // State register: FSM state, counters, lives and the registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= c_ST_IDLE;
            r_frame_cnt     <= '0;
            r_move_cnt      <= '0;
            r_lives         <= c_LIVES_INIT;
            r_start_prev    <= 1'b0;
            r_move_en       <= 1'b0;
            r_sprites_reset <= 1'b1;
            r_freeze        <= 1'b1;
            r_game_over     <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_frame_cnt     <= w_frame_cnt_nxt;
            r_move_cnt      <= w_move_cnt_nxt;
            r_lives         <= w_lives_nxt;
            r_start_prev    <= start_btn;
            r_move_en       <= w_move_en_nxt;
            r_sprites_reset <= w_sprites_reset_nxt;
            r_freeze        <= w_freeze_nxt;
            r_game_over     <= w_game_over_nxt;
        end
    end

    // Next-state logic: transitions, counter updates, lives bookkeeping
    always_comb begin
        w_state_nxt     = r_state;
        w_frame_cnt_nxt = r_frame_cnt;
        w_move_cnt_nxt  = r_move_cnt;
        w_lives_nxt     = r_lives;
        w_move_en_nxt   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_pe) begin
                    w_state_nxt     = c_ST_READY;
                    w_frame_cnt_nxt = '0;
                end
            end
            c_ST_READY: begin
                if (frame_tick) begin
                    if (r_frame_cnt == c_READY_LAST) begin
                        w_state_nxt     = c_ST_PLAY;
                        w_frame_cnt_nxt = '0;
                        w_move_cnt_nxt  = '0;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + c_CNT_ONE;
                    end
                end
            end
            c_ST_PLAY: begin
                // A death wins over a simultaneous frame tick: no step is taken
                if (pacman_is_dead) begin
                    w_state_nxt     = c_ST_DYING;
                    w_lives_nxt     = r_lives - c_LIVES_ONE;
                    w_frame_cnt_nxt = '0;
                    w_move_cnt_nxt  = '0;
                end else if (frame_tick) begin
                    if (r_move_cnt == c_MOVE_LAST) begin
                        w_move_en_nxt  = 1'b1;
                        w_move_cnt_nxt = '0;
                    end else begin
                        w_move_cnt_nxt = r_move_cnt + c_CNT_ONE;
                    end
                end
            end
            c_ST_DYING: begin
                if (frame_tick) begin
                    if (r_frame_cnt == c_DEATH_LAST) begin
                        w_frame_cnt_nxt = '0;
                        // Lives were already taken on entry; zero means no respawn
                        if (r_lives == '0) begin
                            w_state_nxt = c_ST_GAME_OVER;
                        end else begin
                            w_state_nxt = c_ST_READY;
                        end
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + c_CNT_ONE;
                    end
                end
            end
            c_ST_GAME_OVER: begin
                if (w_start_pe) begin
                    w_state_nxt     = c_ST_READY;
                    w_lives_nxt     = c_LIVES_INIT;
                    w_frame_cnt_nxt = '0;
                    w_move_cnt_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt     = c_ST_IDLE;
                w_frame_cnt_nxt = '0;
                w_move_cnt_nxt  = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so registered levels align with it
    always_comb begin
        w_sprites_reset_nxt = 1'b1;
        w_freeze_nxt        = 1'b1;
        w_game_over_nxt     = 1'b0;
        case (w_state_nxt)
            c_ST_PLAY: begin
                w_sprites_reset_nxt = 1'b0;
                w_freeze_nxt        = 1'b0;
            end
            c_ST_DYING: begin
                w_sprites_reset_nxt = 1'b0;
            end
            c_ST_GAME_OVER: begin
                w_game_over_nxt = 1'b1;
            end
            default: begin
                w_sprites_reset_nxt = 1'b1;
            end
        endcase
    end

    assign move_en       = r_move_en;
    assign sprites_reset = r_sprites_reset;
    assign freeze        = r_freeze;
    assign lives_left    = r_lives;
    assign game_over     = r_game_over;
    assign game_state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_flow_controller
//  Description : Self-checking bench for game_flow_controller: directed
//                per-cycle vector table, async reset corner, and a random
//                run against a countdown-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_game_flow_controller;

    localparam int NUM_LIVES    = 2;
    localparam int LIVES_W      = 3;
    localparam int READY_FRAMES = 3;
    localparam int DEATH_FRAMES = 2;
    localparam int MOVE_DIV     = 2;
    localparam int CNT_W        = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_btn = 1'b0;
    logic               frame_tick = 1'b0;
    logic               pacman_is_dead = 1'b0;
    logic               move_en;
    logic               sprites_reset;
    logic               freeze;
    logic [LIVES_W-1:0] lives_left;
    logic               game_over;
    logic [2:0]         game_state;

    int n_checks = 0;
    int n_errors = 0;

    game_flow_controller #(
        .NUM_LIVES    (NUM_LIVES),
        .LIVES_W      (LIVES_W),
        .READY_FRAMES (READY_FRAMES),
        .DEATH_FRAMES (DEATH_FRAMES),
        .MOVE_DIV     (MOVE_DIV),
        .CNT_W        (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_btn      (start_btn),
        .frame_tick     (frame_tick),
        .pacman_is_dead (pacman_is_dead),
        .move_en        (move_en),
        .sprites_reset  (sprites_reset),
        .freeze         (freeze),
        .lives_left     (lives_left),
        .game_over      (game_over),
        .game_state     (game_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       tick;
        logic       dead;
        logic [2:0] st;
        int         lives;
        logic       me;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic t, input logic d,
                       input logic [2:0] st, input int lv, input logic me);
        vec_t v;
        v.start = s; v.tick = t; v.dead = d; v.st = st; v.lives = lv; v.me = me;
        vecs.push_back(v);
    endtask

    // Compares every output against expectations; sprites_reset/freeze/game_over derive from state
    task automatic check(input string name, input logic [2:0] st, input int lv, input logic me);
        logic exp_sr, exp_fr, exp_go;
        exp_sr = (st == 3'd0) || (st == 3'd1) || (st == 3'd4);
        exp_fr = (st != 3'd2);
        exp_go = (st == 3'd4);
        n_checks++;
        if (game_state !== st || int'(lives_left) != lv || move_en !== me ||
            sprites_reset !== exp_sr || freeze !== exp_fr || game_over !== exp_go) begin
            n_errors++;
            $display("FAIL %s: got st=%0d lives=%0d me=%b sr=%b fr=%b go=%b, expected st=%0d lives=%0d me=%b sr=%b fr=%b go=%b",
                     name, game_state, lives_left, move_en, sprites_reset, freeze, game_over,
                     st, lv, me, exp_sr, exp_fr, exp_go);
        end
    endtask

    // Reference model: countdown of remaining frames per phase, tick count in PLAY
    int m_state, m_lives, m_left, m_play_ticks;
    logic m_prev, m_move;

    task automatic model_reset();
        m_state = 0; m_lives = NUM_LIVES; m_left = 0; m_play_ticks = 0;
        m_prev = 1'b0; m_move = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic t, input logic d);
        logic pe;
        pe = s && !m_prev;
        m_prev = s;
        m_move = 1'b0;
        case (m_state)
            0: if (pe) begin m_state = 1; m_left = READY_FRAMES; end
            1: if (t) begin
                m_left = m_left - 1;
                if (m_left == 0) begin m_state = 2; m_play_ticks = 0; end
            end
            2: if (d) begin
                m_state = 3; m_lives = m_lives - 1; m_left = DEATH_FRAMES;
            end else if (t) begin
                m_play_ticks = m_play_ticks + 1;
                if (m_play_ticks % MOVE_DIV == 0) m_move = 1'b1;
            end
            3: if (t) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (m_lives == 0) m_state = 4;
                    else begin m_state = 1; m_left = READY_FRAMES; end
                end
            end
            default: if (pe) begin m_state = 1; m_lives = NUM_LIVES; m_left = READY_FRAMES; end
        endcase
    endtask

    initial begin
        // ---------------- directed vector table ----------------
        //    start tick dead  state lives move_en
        add(0, 0, 0, 3'd0, 2, 0);   // idle, nothing happens
        add(0, 1, 1, 3'd0, 2, 0);   // tick/dead ignored in IDLE
        add(0, 1, 0, 3'd0, 2, 0);
        add(1, 0, 0, 3'd1, 2, 0);   // start edge -> READY
        add(0, 1, 0, 3'd1, 2, 0);   // ready tick 1
        add(0, 1, 0, 3'd1, 2, 0);   // ready tick 2
        add(0, 1, 0, 3'd2, 2, 0);   // ready tick 3 -> PLAY
        add(0, 1, 0, 3'd2, 2, 0);   // play tick 1
        add(0, 0, 0, 3'd2, 2, 0);
        add(0, 1, 0, 3'd2, 2, 1);   // play tick 2 -> pulse
        add(0, 0, 0, 3'd2, 2, 0);   // pulse lasts one cycle
        add(0, 1, 0, 3'd2, 2, 0);   // tick 3
        add(0, 1, 0, 3'd2, 2, 1);   // tick 4 -> pulse
        add(0, 1, 0, 3'd2, 2, 0);   // tick 5, back-to-back ticks
        add(0, 1, 0, 3'd2, 2, 1);   // tick 6 -> pulse
        add(0, 1, 1, 3'd3, 1, 0);   // dead with tick: dying, no pulse
        add(0, 1, 0, 3'd3, 1, 0);   // dying tick 1
        add(0, 1, 0, 3'd1, 1, 0);   // dying tick 2 -> respawn READY
        add(0, 1, 1, 3'd1, 1, 0);   // dead ignored in READY
        add(0, 1, 0, 3'd1, 1, 0);
        add(0, 1, 0, 3'd2, 1, 0);   // -> PLAY
        add(1, 0, 1, 3'd3, 0, 0);   // second death, start ignored
        add(0, 1, 0, 3'd3, 0, 0);
        add(0, 1, 0, 3'd4, 0, 0);   // -> GAME_OVER
        add(0, 1, 0, 3'd4, 0, 0);
        add(1, 0, 0, 3'd1, 2, 0);   // restart, lives refilled
        add(1, 0, 0, 3'd1, 2, 0);   // held start: no second restart
        add(1, 1, 0, 3'd1, 2, 0);
        add(1, 1, 0, 3'd1, 2, 0);
        add(1, 1, 0, 3'd2, 2, 0);   // PLAY, start still held
        add(0, 1, 1, 3'd3, 1, 0);   // death -> DYING
        add(0, 1, 0, 3'd3, 1, 0);   // mid-DYING

        #12;
        check("reset_state", 3'd0, NUM_LIVES, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            start_btn = vecs[i].start; frame_tick = vecs[i].tick; pacman_is_dead = vecs[i].dead;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].lives, vecs[i].me);
        end

        // ---------------- async reset in DYING ----------------
        @(negedge clk);
        start_btn = 1'b0; frame_tick = 1'b0; pacman_is_dead = 1'b0;
        #2 rst = 1'b1;
        #1 check("async_rst_dying", 3'd0, NUM_LIVES, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- randomized run vs reference model ----------------
        model_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (i == 2000) begin
                start_btn = 1'b0; frame_tick = 1'b0; pacman_is_dead = 1'b0;
                rst = 1'b1;
                #1;
                model_reset();
                check("rand_async_rst", 3'd0, m_lives, 1'b0);
                @(negedge clk);
                rst = 1'b0;
            end else begin
                start_btn      = ($urandom_range(0, 5) == 0);
                frame_tick     = ($urandom_range(0, 2) == 0);
                pacman_is_dead = ($urandom_range(0, 12) == 0);
                @(posedge clk);
                model_step(start_btn, frame_tick, pacman_is_dead);
                #1;
                check($sformatf("rand%0d", i), 3'(m_state), m_lives, m_move);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
